// File: rtl/gci_std_display_vram_write_queue_pkg.sv
// Shared types and constants for the VRAM pixel write queue.
package gci_std_display_vram_write_queue_pkg;

    typedef enum logic [1:0] {
        FLUSH_IDLE  = 2'h0,
        FLUSH_DRAIN = 2'h1,
        FLUSH_DONE  = 2'h2
    } flush_state_t;

    localparam logic [3:0] L_BYTEENA = 4'b0111;
    localparam int         L_RGB_N   = 24;

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// First-word-fall-through synchronous FIFO; only pointers and count are reset.
module gci_std_display_sync_fifo
    import gci_std_display_vram_write_queue_pkg::*;
#(
    parameter int P_WIDTH   = 47,
    parameter int P_DEPTH   = 16,
    parameter int P_DEPTH_N = 4
)(
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iRESET_SYNC,
    input  logic                 iWR_EN,
    input  logic [P_WIDTH-1:0]   iWR_DATA,
    input  logic                 iRD_EN,
    output logic [P_WIDTH-1:0]   oRD_DATA,
    output logic                 oFULL,
    output logic                 oEMPTY,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    localparam logic [P_DEPTH_N:0] L_FULL_COUNT = (P_DEPTH_N+1)'(P_DEPTH);

    logic [P_WIDTH-1:0]   mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] wr_ptr;
    logic [P_DEPTH_N-1:0] rd_ptr;
    logic [P_DEPTH_N:0]   count;
    logic                 wr_go;
    logic                 rd_go;

    assign oFULL    = (count == L_FULL_COUNT);
    assign oEMPTY   = (count == '0);
    assign oCOUNT   = count;
    assign oRD_DATA = mem[rd_ptr];
    assign wr_go    = iWR_EN && !oFULL;
    assign rd_go    = iRD_EN && !oEMPTY;

    always_ff @(posedge iCLOCK) begin
        if (wr_go) begin
            mem[wr_ptr] <= iWR_DATA;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_go) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_go, rd_go})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gci_std_display_vram_write_queue.sv
// Pixel write queue between the pixel generator and the VRAM port, with flush/drain notification.
module gci_std_display_vram_write_queue
    import gci_std_display_vram_write_queue_pkg::*;
#(
    parameter int P_MEM_ADDR_N = 23,
    parameter int P_DEPTH      = 16,
    parameter int P_DEPTH_N    = 4
)(
    input  logic                    iCLOCK,
    input  logic                    iRESET,
    input  logic                    iRESET_SYNC,
    input  logic                    iIF_VALID,
    output logic                    oIF_BUSY,
    input  logic [P_MEM_ADDR_N-1:0] iIF_ADDR,
    input  logic [L_RGB_N-1:0]      iIF_DATA,
    input  logic                    iFLUSH,
    output logic                    oFLUSH_DONE,
    output logic                    oMEM_VALID,
    input  logic                    iMEM_BUSY,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [31:0]             oMEM_DATA,
    output logic [3:0]              oMEM_BYTEENA,
    output logic [P_DEPTH_N:0]      oCOUNT
);

    localparam int L_WIDTH = P_MEM_ADDR_N + L_RGB_N;

    flush_state_t         flush_state;
    logic                 flush_done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [L_WIDTH-1:0]   fifo_rdata;
    logic                 push;
    logic                 pop;

    // Busy depends on registers only, never on the memory-side stall.
    assign oIF_BUSY = fifo_full || (flush_state != FLUSH_IDLE);
    assign push     = iIF_VALID && !oIF_BUSY;
    assign pop      = !fifo_empty && !iMEM_BUSY;

    gci_std_display_sync_fifo #(
        .P_WIDTH   (L_WIDTH),
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N)
    ) u_fifo (
        .iCLOCK      (iCLOCK),
        .iRESET      (iRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iWR_EN      (push),
        .iWR_DATA    ({iIF_ADDR, iIF_DATA}),
        .iRD_EN      (pop),
        .oRD_DATA    (fifo_rdata),
        .oFULL       (fifo_full),
        .oEMPTY      (fifo_empty),
        .oCOUNT      (oCOUNT)
    );

    // Storage is not reset, so the memory bus is forced to zero while idle.
    assign oMEM_VALID   = !fifo_empty;
    assign oMEM_ADDR    = oMEM_VALID ? fifo_rdata[L_WIDTH-1:L_RGB_N] : '0;
    assign oMEM_DATA    = oMEM_VALID ? {8'h00, fifo_rdata[L_RGB_N-1:0]} : 32'h0;
    assign oMEM_BYTEENA = oMEM_VALID ? L_BYTEENA : 4'b0000;
    assign oFLUSH_DONE  = flush_done;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            flush_state <= FLUSH_IDLE;
            flush_done  <= 1'b0;
        end else if (iRESET_SYNC) begin
            flush_state <= FLUSH_IDLE;
            flush_done  <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (flush_state)
                FLUSH_IDLE: begin
                    if (iFLUSH) begin
                        flush_state <= FLUSH_DRAIN;
                    end
                end
                FLUSH_DRAIN: begin
                    if (fifo_empty) begin
                        flush_state <= FLUSH_DONE;
                        flush_done  <= 1'b1;
                    end
                end
                FLUSH_DONE: begin
                    flush_state <= FLUSH_IDLE;
                end
                default: begin
                    flush_state <= FLUSH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gci_std_display_vram_write_queue.sv
// Randomised scoreboard bench for the VRAM pixel write queue.
module tb_gci_std_display_vram_write_queue;

    localparam int AW    = 23;
    localparam int DEPTH = 16;
    localparam int DN    = 4;

    logic          iCLOCK = 1'b0;
    logic          iRESET = 1'b1;
    logic          iRESET_SYNC = 1'b0;
    logic          iIF_VALID = 1'b0;
    logic          oIF_BUSY;
    logic [AW-1:0] iIF_ADDR = '0;
    logic [23:0]   iIF_DATA = '0;
    logic          iFLUSH = 1'b0;
    logic          oFLUSH_DONE;
    logic          oMEM_VALID;
    logic          iMEM_BUSY = 1'b0;
    logic [AW-1:0] oMEM_ADDR;
    logic [31:0]   oMEM_DATA;
    logic [3:0]    oMEM_BYTEENA;
    logic [DN:0]   oCOUNT;

    gci_std_display_vram_write_queue #(
        .P_MEM_ADDR_N (AW),
        .P_DEPTH      (DEPTH),
        .P_DEPTH_N    (DN)
    ) dut (
        .iCLOCK       (iCLOCK),
        .iRESET       (iRESET),
        .iRESET_SYNC  (iRESET_SYNC),
        .iIF_VALID    (iIF_VALID),
        .oIF_BUSY     (oIF_BUSY),
        .iIF_ADDR     (iIF_ADDR),
        .iIF_DATA     (iIF_DATA),
        .iFLUSH       (iFLUSH),
        .oFLUSH_DONE  (oFLUSH_DONE),
        .oMEM_VALID   (oMEM_VALID),
        .iMEM_BUSY    (iMEM_BUSY),
        .oMEM_ADDR    (oMEM_ADDR),
        .oMEM_DATA    (oMEM_DATA),
        .oMEM_BYTEENA (oMEM_BYTEENA),
        .oCOUNT       (oCOUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted pixels plus occupancy and flush phase.
    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   rgb;
    } pix_t;

    pix_t q[$];
    int   m_cnt   = 0;
    int   m_phase = 0;   // 0: no flush, 1: draining, 2: done pulse visible
    int   arst_req = 0;
    int   arst_ack = 0;

    always @(negedge iCLOCK) begin
        bit   mbusy;
        bit   mvalid;
        bit   acc;
        bit   pp;
        int   old_cnt;
        pix_t p;
        if (arst_req != arst_ack) begin
            arst_ack = arst_req;
            q.delete();
            m_cnt   = 0;
            m_phase = 0;
        end
        mbusy  = (m_cnt == DEPTH) || (m_phase != 0);
        mvalid = (m_cnt != 0);
        chk("count", 64'(oCOUNT), 64'(m_cnt));
        chk("if_busy", 64'(oIF_BUSY), 64'(mbusy));
        chk("mem_valid", 64'(oMEM_VALID), 64'(mvalid));
        chk("flush_done", 64'(oFLUSH_DONE), 64'(m_phase == 2));
        if (!mvalid) begin
            chk("idle_bus", {oMEM_BYTEENA, oMEM_DATA, 5'b0, oMEM_ADDR}, 64'h0);
        end
        if (iRESET || iRESET_SYNC) begin
            q.delete();
            m_cnt   = 0;
            m_phase = 0;
        end else begin
            acc     = iIF_VALID && !mbusy;
            pp      = mvalid && !iMEM_BUSY;
            old_cnt = m_cnt;
            if (acc) begin
                p.addr = iIF_ADDR;
                p.rgb  = iIF_DATA;
                q.push_back(p);
            end
            m_cnt = m_cnt + int'(acc) - int'(pp);
            case (m_phase)
                0: if (iFLUSH) m_phase = 1;
                1: if (old_cnt == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
    end

    // Monitor: every accepted memory write must match the oldest queued pixel.
    always @(negedge iCLOCK) begin
        pix_t e;
        if (oMEM_VALID && !iMEM_BUSY && !iRESET && !iRESET_SYNC) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_pop", 64'(oMEM_ADDR), 64'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("mem_addr", 64'(oMEM_ADDR), 64'(e.addr));
                chk("mem_data", 64'(oMEM_DATA), {40'h0, 8'h00, e.rgb});
                chk("mem_byteena", 64'(oMEM_BYTEENA), 64'h7);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge iCLOCK);
            #1;
        end
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            iIF_VALID = 1'b1;
            iIF_ADDR  = AW'(base + i);
            iIF_DATA  = 24'($urandom);
            cyc();
        end
        iIF_VALID = 1'b0;
    endtask

    initial begin
        bit seen;
        cyc(2);
        chk("reset_valid", 64'(oMEM_VALID), 64'h0);
        chk("reset_count", 64'(oCOUNT), 64'h0);
        iRESET = 1'b0;
        cyc();

        // single pixel, 1-cycle latency
        iIF_VALID = 1'b1;
        iIF_ADDR  = 23'h000123;
        iIF_DATA  = 24'hFF8000;
        cyc();
        iIF_VALID = 1'b0;
        chk("lat_valid", 64'(oMEM_VALID), 64'h1);
        chk("lat_addr", 64'(oMEM_ADDR), 64'h123);
        chk("lat_data", 64'(oMEM_DATA), 64'h00FF8000);
        chk("lat_be", 64'(oMEM_BYTEENA), 64'h7);
        cyc();
        chk("lat_after_valid", 64'(oMEM_VALID), 64'h0);
        chk("lat_after_count", 64'(oCOUNT), 64'h0);

        // fill to full, 17th dropped, then drain in order
        iMEM_BUSY = 1'b1;
        push_n(17, 0);
        chk("full_count", 64'(oCOUNT), 64'd16);
        chk("full_busy", 64'(oIF_BUSY), 64'h1);
        iMEM_BUSY = 1'b0;
        cyc(20);

        // full with simultaneous pop: push refused
        iMEM_BUSY = 1'b1;
        push_n(16, 32);
        iMEM_BUSY = 1'b0;
        iIF_VALID = 1'b1;
        iIF_ADDR  = 23'h7ABCDE;
        cyc();
        iIF_VALID = 1'b0;
        iMEM_BUSY = 1'b1;
        chk("fullpop_count", 64'(oCOUNT), 64'd15);
        chk("fullpop_busy", 64'(oIF_BUSY), 64'h0);
        push_n(1, 100);
        chk("refill_count", 64'(oCOUNT), 64'd16);
        iMEM_BUSY = 1'b0;
        cyc(20);

        // flush with 8 pending
        iMEM_BUSY = 1'b1;
        push_n(8, 200);
        iFLUSH = 1'b1;
        cyc();
        iFLUSH = 1'b0;
        chk("flush_busy", 64'(oIF_BUSY), 64'h1);
        iMEM_BUSY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = oFLUSH_DONE;
        end
        chk("flush_done_seen", 64'(seen), 64'h1);
        cyc();
        chk("flush_done_width", 64'(oFLUSH_DONE), 64'h0);
        chk("flush_release_busy", 64'(oIF_BUSY), 64'h0);

        // flush on empty queue
        iFLUSH = 1'b1;
        cyc();
        iFLUSH = 1'b0;
        chk("eflush_t1", 64'(oFLUSH_DONE), 64'h0);
        cyc();
        chk("eflush_t2", 64'(oFLUSH_DONE), 64'h1);
        cyc(3);

        // synchronous clear with 5 pending
        iMEM_BUSY = 1'b1;
        push_n(5, 300);
        iRESET_SYNC = 1'b1;
        cyc();
        iRESET_SYNC = 1'b0;
        chk("sreset_valid", 64'(oMEM_VALID), 64'h0);
        chk("sreset_count", 64'(oCOUNT), 64'h0);

        // asynchronous reset mid-cycle with 5 pending
        push_n(5, 400);
        #1;
        iRESET = 1'b1;
        #1;
        chk("areset_valid", 64'(oMEM_VALID), 64'h0);
        chk("areset_count", 64'(oCOUNT), 64'h0);
        chk("areset_be", 64'(oMEM_BYTEENA), 64'h0);
        arst_req++;
        #1;
        iRESET = 1'b0;
        iMEM_BUSY = 1'b0;
        cyc(2);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            iIF_VALID = ($urandom_range(0, 3) != 0);
            iIF_ADDR  = AW'($urandom);
            iIF_DATA  = 24'($urandom);
            iMEM_BUSY = ($urandom_range(0, 2) == 0);
            iFLUSH    = ($urandom_range(0, 60) == 0);
            cyc();
        end
        iIF_VALID = 1'b0;
        iFLUSH    = 1'b0;
        iMEM_BUSY = 1'b0;
        cyc(40);
        chk("sb_drained", 64'(q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
